// File: rtl/tx_frame_sender.sv
// tx_frame_sender
//   Pulls a frame length from a show-ahead length FIFO and then that many
//   beats from a show-ahead data FIFO, pushing them to a MAC over a
//   valid/ready interface. Short frames are padded with PAD_VAL up to
//   MIN_LEN beats. After each frame an inter-frame gap of IFG idle cycles
//   is held.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   len_data/empty/rd length FIFO head, empty flag, pop strobe
//   byte_data/empty/rd data FIFO head, empty flag, pop strobe
//   tx_data/valid/last MAC beat, registered output stage
//   tx_ready          MAC accepts the current beat
//   busy              high whenever a frame is in flight (not IDLE)
//   frames_sent       wrapping count of completed frames
//   underrun          one-cycle pulse for each load slot starved of data
module tx_frame_sender #(
    parameter int DATA_W  = 8,
    parameter int LEN_W   = 16,
    parameter int MIN_LEN = 60,
    parameter int PAD_VAL = 0,
    parameter int IFG     = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LEN_W-1:0]  len_data,
    input  logic              len_empty,
    output logic              len_rd,
    input  logic [DATA_W-1:0] byte_data,
    input  logic              byte_empty,
    output logic              byte_rd,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    output logic              tx_last,
    input  logic              tx_ready,
    output logic              busy,
    output logic [15:0]       frames_sent,
    output logic              underrun
);

    if ((MIN_LEN >> LEN_W) != 0) begin : g_bad_min_len
        $error("tx_frame_sender: MIN_LEN does not fit in LEN_W bits");
    end

    localparam logic [LEN_W-1:0]  MIN_LEN_C = LEN_W'(MIN_LEN);
    localparam logic [DATA_W-1:0] PAD_C     = DATA_W'(PAD_VAL);
    // Last GAP counter value before returning to IDLE.
    localparam logic [15:0]       IFG_M1    = (IFG == 0) ? 16'd0 : 16'(IFG - 1);

    typedef enum logic [1:0] {IDLE, SEND, PAD, GAP} state_t;

    state_t            r_state, w_state_nxt;
    logic [LEN_W-1:0]  r_len, r_tgt, r_cnt;
    logic [LEN_W-1:0]  w_cnt_inc;
    logic [15:0]       r_ifg;
    logic [15:0]       r_frames;
    logic [DATA_W-1:0] r_tx_data;
    logic              r_tx_valid, r_tx_last;

    logic w_slot;       // output stage may load this cycle
    logic w_start;      // accept a non-zero length
    logic w_drop;       // discard a zero length
    logic w_load_data;  // load a data beat (pops the data FIFO)
    logic w_load_pad;   // load a pad beat
    logic w_starve;     // SEND slot free but no data
    logic w_last_acc;   // final beat of the frame accepted

    assign w_slot    = !r_tx_valid || tx_ready;
    assign w_cnt_inc = r_cnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_drop      = 1'b0;
        w_load_data = 1'b0;
        w_load_pad  = 1'b0;
        w_starve    = 1'b0;
        w_last_acc  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!len_empty) begin
                    if (len_data == '0) begin
                        w_drop = 1'b1;
                    end else begin
                        w_start     = 1'b1;
                        w_state_nxt = SEND;
                    end
                end
            end
            SEND: begin
                // cnt < len always holds here: we leave SEND on the last data beat.
                if (w_slot) begin
                    if (!byte_empty) begin
                        w_load_data = 1'b1;
                        if (w_cnt_inc == r_len)
                            w_state_nxt = (r_len < MIN_LEN_C) ? PAD : GAP;
                    end else begin
                        w_starve = 1'b1;
                    end
                end
            end
            PAD: begin
                if (w_slot) begin
                    w_load_pad = 1'b1;
                    if (w_cnt_inc == r_tgt)
                        w_state_nxt = GAP;
                end
            end
            GAP: begin
                // First drain the final beat, then count IFG empty cycles.
                if (r_tx_valid) begin
                    if (tx_ready) begin
                        w_last_acc = 1'b1;
                        if (IFG == 0)
                            w_state_nxt = IDLE;
                    end
                end else if (r_ifg == IFG_M1) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_len      <= '0;
            r_tgt      <= '0;
            r_cnt      <= '0;
            r_ifg      <= '0;
            r_frames   <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_tx_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_len <= len_data;
                r_tgt <= (len_data < MIN_LEN_C) ? MIN_LEN_C : len_data;
                r_cnt <= '0;
            end
            if (w_load_data || w_load_pad) begin
                r_tx_data  <= w_load_data ? byte_data : PAD_C;
                r_tx_valid <= 1'b1;
                r_tx_last  <= (w_cnt_inc == r_tgt);
                r_cnt      <= w_cnt_inc;
            end else if (w_starve) begin
                r_tx_valid <= 1'b0;
            end
            if (w_last_acc) begin
                r_tx_valid <= 1'b0;
                r_tx_last  <= 1'b0;
                r_frames   <= r_frames + 16'd1;
                r_ifg      <= '0;
            end else if (r_state == GAP && !r_tx_valid) begin
                r_ifg <= r_ifg + 16'd1;
            end
        end
    end

    // Strobes are gated by rst so they drop the moment reset asserts,
    // even while a FIFO still presents data.
    assign len_rd      = rst && (w_start || w_drop);
    assign byte_rd     = rst && w_load_data;
    assign underrun    = rst && w_starve;
    assign busy        = (r_state != IDLE);
    assign tx_data     = r_tx_data;
    assign tx_valid    = r_tx_valid;
    assign tx_last     = r_tx_last;
    assign frames_sent = r_frames;

endmodule

// File: tb/tb_tx_frame_sender.sv
module tb_tx_frame_sender;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] len_data;
    logic        len_empty;
    logic        len_rd;
    logic [7:0]  byte_data;
    logic        byte_empty;
    logic        byte_rd;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_last;
    logic        tx_ready;
    logic        busy;
    logic [15:0] frames_sent;
    logic        underrun;

    tx_frame_sender dut (
        .clk(clk), .rst(rst),
        .len_data(len_data), .len_empty(len_empty), .len_rd(len_rd),
        .byte_data(byte_data), .byte_empty(byte_empty), .byte_rd(byte_rd),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
        .tx_ready(tx_ready), .busy(busy), .frames_sent(frames_sent),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] lq[$];
    logic [7:0]  bq[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  rx[$];
    logic        rxl[$];
    int          rxc[$];
    int          cyc = 0;
    int          n_under = 0;
    int          n_brd = 0;
    int          n_lrd = 0;
    bit          tog = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Show-ahead FIFO heads follow the bench queues.
    task automatic refresh();
        len_empty  = (lq.size() == 0);
        len_data   = len_empty ? 16'd0 : lq[0];
        byte_empty = (bq.size() == 0);
        byte_data  = byte_empty ? 8'd0 : bq[0];
    endtask

    // One clock: sample this cycle's outputs, take the edge, apply pops.
    task automatic step();
        logic       l, b, stall;
        logic [7:0] sd;
        logic       sl;
        if (tx_valid && tx_ready) begin
            rx.push_back(tx_data);
            rxl.push_back(tx_last);
            rxc.push_back(cyc);
        end
        if (underrun) n_under++;
        if (byte_rd)  n_brd++;
        if (len_rd)   n_lrd++;
        stall = tx_valid && !tx_ready;
        sd = tx_data;
        sl = tx_last;
        l = len_rd;
        b = byte_rd;
        @(posedge clk);
        #1;
        cyc++;
        if (l && lq.size() != 0) void'(lq.pop_front());
        if (b && bq.size() != 0) void'(bq.pop_front());
        refresh();
        if (tog) tx_ready = !tx_ready;
        #1;
        if (stall) begin
            chk("stall_valid", tx_valid, 1);
            chk("stall_data", tx_data, sd);
            chk("stall_last", tx_last, sl);
        end
    endtask

    task automatic run_beats(input int n, input int budget, input string tag);
        int k = 0;
        while (rx.size() < n && k < budget) begin
            step();
            k++;
        end
        chk(tag, rx.size(), n);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 100) begin
            step();
            k++;
        end
        chk(tag, busy, 0);
    endtask

    task automatic clear_rx();
        rx.delete();
        rxl.delete();
        rxc.delete();
        exp_q.delete();
        n_under = 0;
        n_brd = 0;
        n_lrd = 0;
    endtask

    // Compare the received frame: data beats, then pad zeros up to total,
    // tx_last only on the final beat.
    task automatic check_frame(input string tag, input int total);
        int err_d = 0, lasts = 0;
        for (int i = 0; i < rx.size(); i++) begin
            logic [7:0] e;
            e = (i < exp_q.size()) ? exp_q[i] : 8'h00;
            if (rx[i] !== e) err_d++;
            if (rxl[i]) lasts++;
        end
        chk({tag, "_beats"}, rx.size(), total);
        chk({tag, "_data_errs"}, err_d, 0);
        chk({tag, "_last_count"}, lasts, 1);
        if (rx.size() == total) chk({tag, "_last_pos"}, rxl[total-1], 1);
    endtask

    initial begin
        int lowc, idlec;
        rst = 1'b0;
        tx_ready = 1'b1;
        refresh();
        step();
        step();
        // Reset state, with a length already waiting: nothing may pop.
        lq.push_back(16'd64);
        for (int i = 0; i < 64; i++) begin
            bq.push_back(8'(i * 3 + 1));
            exp_q.push_back(8'(i * 3 + 1));
        end
        refresh();
        #1;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_last", tx_last, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_len_rd", len_rd, 0);
        chk("rst_byte_rd", byte_rd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frames", frames_sent, 0);
        chk("rst_underrun", underrun, 0);

        // Frame 1: len=64, continuous ready. Latency: pop now, beat 2 cycles on.
        rst = 1'b1;
        #1;
        chk("lat_len_rd", len_rd, 1);
        step();
        chk("lat_c1_valid", tx_valid, 0);
        chk("lat_c1_byte_rd", byte_rd, 1);
        step();
        chk("lat_c2_valid", tx_valid, 1);
        chk("lat_c2_data", tx_data, 8'h01);
        run_beats(64, 200, "f1_done");
        check_frame("f1", 64);
        if (rxc.size() == 64) chk("f1_consecutive", rxc[63] - rxc[0], 63);
        chk("f1_frames", frames_sent, 1);
        chk("f1_busy_in_gap", busy, 1);

        // Queue frame 2 now and measure the gap: 12 GAP + 1 IDLE + 1 load cycle.
        clear_rx();
        lq.push_back(16'd10);
        for (int i = 0; i < 10; i++) begin
            bq.push_back(8'(8'hA0 + i));
            exp_q.push_back(8'(8'hA0 + i));
        end
        refresh();
        #1;
        lowc = 0;
        idlec = 0;
        while (!tx_valid && lowc < 50) begin
            lowc++;
            if (!busy) idlec++;
            step();
        end
        chk("ifg_low_cycles", lowc, 14);
        chk("ifg_idle_cycles", idlec, 1);

        // Frame 2: len=10 -> 10 data + 50 pad beats.
        run_beats(60, 200, "f2_done");
        check_frame("f2", 60);
        chk("f2_byte_rd_count", n_brd, 10);
        wait_idle("f2_idle");
        chk("f2_frames", frames_sent, 2);

        // Frame 3: zero length dropped, then len=61.
        clear_rx();
        lq.push_back(16'd0);
        lq.push_back(16'd61);
        for (int i = 0; i < 61; i++) begin
            bq.push_back(8'(255 - i));
            exp_q.push_back(8'(255 - i));
        end
        refresh();
        #1;
        step();
        chk("f3_drop_idle", busy, 0);
        chk("f3_drop_no_valid", tx_valid, 0);
        run_beats(61, 200, "f3_done");
        check_frame("f3", 61);
        chk("f3_len_pops", n_lrd, 2);
        chk("f3_byte_pops", n_brd, 61);
        wait_idle("f3_idle");
        chk("f3_frames", frames_sent, 3);

        // Frame 4: len=64 with tx_ready toggling every cycle.
        clear_rx();
        lq.push_back(16'd64);
        for (int i = 0; i < 64; i++) begin
            bq.push_back(8'(i * 7 + 5));
            exp_q.push_back(8'(i * 7 + 5));
        end
        refresh();
        tog = 1'b1;
        #1;
        run_beats(64, 400, "f4_done");
        check_frame("f4", 64);
        tog = 1'b0;
        tx_ready = 1'b1;
        wait_idle("f4_idle");
        chk("f4_frames", frames_sent, 4);

        // Frame 5: data runs dry after beat 20 for 5 load slots.
        clear_rx();
        lq.push_back(16'd64);
        for (int i = 0; i < 64; i++) exp_q.push_back(8'(i + 8'h40));
        for (int i = 0; i < 20; i++) bq.push_back(8'(i + 8'h40));
        refresh();
        #1;
        begin
            int k = 0;
            while (n_under < 5 && k < 200) begin
                step();
                k++;
            end
        end
        chk("f5_under_reached", n_under, 5);
        chk("f5_beats_at_gap", rx.size(), 20);
        chk("f5_valid_in_gap", tx_valid, 0);
        chk("f5_busy_in_gap", busy, 1);
        for (int i = 20; i < 64; i++) bq.push_back(8'(i + 8'h40));
        refresh();
        #1;
        run_beats(64, 200, "f5_done");
        check_frame("f5", 64);
        chk("f5_under_total", n_under, 5);
        wait_idle("f5_idle");
        chk("f5_frames", frames_sent, 5);

        // Frame 6: reset after beat 30, then the next length (5) goes out.
        clear_rx();
        lq.push_back(16'd64);
        lq.push_back(16'd5);
        for (int i = 0; i < 64; i++) bq.push_back(8'(i + 8'h80));
        refresh();
        #1;
        run_beats(30, 200, "f6_beat30");
        rst = 1'b0;
        #1;
        chk("mrst_tx_valid", tx_valid, 0);
        chk("mrst_tx_last", tx_last, 0);
        chk("mrst_tx_data", tx_data, 0);
        chk("mrst_len_rd", len_rd, 0);
        chk("mrst_byte_rd", byte_rd, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_frames", frames_sent, 0);
        chk("mrst_underrun", underrun, 0);
        chk("mrst_len_left", lq.size(), 1);
        // The data FIFO is flushed along with the sender.
        bq.delete();
        clear_rx();
        for (int i = 0; i < 5; i++) begin
            bq.push_back(8'(8'hC0 + i));
            exp_q.push_back(8'(8'hC0 + i));
        end
        refresh();
        step();
        step();
        chk("mrst_no_pops", n_brd + n_lrd, 0);
        rst = 1'b1;
        #1;
        run_beats(60, 200, "f6_done");
        check_frame("f6", 60);
        chk("f6_byte_pops", n_brd, 5);
        wait_idle("f6_idle");
        chk("f6_frames", frames_sent, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_frame_sender.md
TX_FRAME_SENDER -- requirements
Module: tx_frame_sender

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_W, 8, byte-lane width.
- LEN_W, 16, frame-length width.
- MIN_LEN, 60, minimum frame length in beats, reached by padding.
- PAD_VAL, 0, pad beat value.
- IFG, 12, idle cycles between frames (0 allowed).

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, reset, asynchronous, active-low.
- len_data, in, LEN_W, head of length FIFO (show-ahead).
- len_empty, in, 1, length FIFO empty.
- len_rd, out, 1, length FIFO pop.
- byte_data, in, DATA_W, head of data FIFO (show-ahead).
- byte_empty, in, 1, data FIFO empty.
- byte_rd, out, 1, data FIFO pop.
- tx_data, out, DATA_W, MAC beat.
- tx_valid, out, 1, beat valid.
- tx_last, out, 1, final beat of frame.
- tx_ready, in, 1, MAC accepts beat.
- busy, out, 1, state not IDLE.
- frames_sent, out, 16, completed-frame count, wraps.
- underrun, out, 1, one-cycle starvation pulse.

Function
REQ-003 FSM states SHALL be IDLE, SEND, PAD, GAP; only transitions listed below allowed.
REQ-004 Beat accept SHALL occur iff tx_valid && tx_ready. Output stage SHALL load only when !tx_valid || tx_ready. tx_data/tx_valid/tx_last SHALL remain stable while tx_valid && !tx_ready.
REQ-005 IDLE, len_empty=0, len_data=0: len_rd=1 for one cycle, length discarded, remain IDLE, no output.
REQ-006 IDLE, len_empty=0, len_data>0: len_rd=1; latch len=len_data, tgt=max(len_data,MIN_LEN), cnt=0; go SEND.
REQ-007 SEND, load slot free, byte_empty=0: byte_rd=1 same cycle (combinational). Register tx_data=byte_data, tx_valid=1, cnt+=1, tx_last=(cnt+1==tgt).
REQ-008 SEND, load slot free, byte_empty=1: tx_valid<=0, underrun=1 for that cycle, stay in SEND; frame resumes when data arrives, never aborts.
REQ-009 When the beat with cnt==len is loaded: if len<MIN_LEN go PAD, else go GAP.
REQ-010 PAD: each free load slot registers tx_data=PAD_VAL, tx_valid=1, cnt+=1, tx_last=(cnt+1==tgt); byte_rd=0. Go GAP when beat cnt==tgt is loaded.
REQ-011 GAP: hold until last beat accepted, then tx_valid<=0, tx_last<=0, frames_sent+=1. Then count IFG idle cycles and return to IDLE; IFG=0 returns to IDLE next cycle.
REQ-012 cnt and tgt SHALL be LEN_W bits; MIN_LEN >= 2^LEN_W is a parameter error.
REQ-013 Latency: len_empty falls in IDLE -> tx_valid=1 exactly 2 cycles later when byte_empty=0.
REQ-014 Each frame SHALL pop exactly len data beats and exactly one length; byte_rd never asserted outside SEND.
REQ-015 busy SHALL be 1 in SEND, PAD, GAP.

Reset
REQ-016 rst=0 SHALL immediately force:
- state=IDLE;
- tx_data=0, tx_valid=0, tx_last=0;
- len_rd=0, byte_rd=0, underrun=0, busy=0;
- cnt=0, tgt=0, frames_sent=0.
REQ-017 Reset mid-frame SHALL drop the frame without popping further. After release, the next frame starts from the next length entry.

Verification
REQ-018 The bench SHALL cover:
- len=64, 64 bytes queued, tx_ready=1 -> 64 consecutive beats, tx_last on beat 64, frames_sent=1, 12 idle cycles before next tx_valid.
- len=10 -> 10 data beats, then 50 beats of 0x00, tx_last on beat 60, byte_rd pulsed exactly 10 times.
- len=0 then len=61 -> zero entry popped silently, single 61-beat frame, frames_sent=1.
- len=64, tx_ready toggling 1/0 each cycle -> data stable while stalled, 64 unique accepts in order.
- byte_empty=1 for 5 cycles after beat 20 -> 5 underrun pulses, tx_valid=0 during gap, frame completes with 64 beats.
- rst low at beat 30 -> all outputs 0 same cycle; after release, next queued length sent correctly.
